// File: rtl/seq_scan_pkg.sv
// -----------------------------------------------------------------------------
// seq_scan_pkg
// Shared types and constants for the sequenced scan controller and its
// embedded serial pattern detector.
//   scan_state_t : controller state encoding (IDLE, LOAD, SHIFT, DONE)
//   DEF_*        : default word width, pattern length and pattern
//   cnt_width()  : bits needed to hold a counter value 0..max_val
// -----------------------------------------------------------------------------
package seq_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } scan_state_t;

  localparam int DEF_WORD_W = 8;
  localparam int DEF_PAT_W  = 4;
  localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 4'b0110;

  // Width of a counter that must reach max_val; never narrower than 1 bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/seq_pattern_match.sv
// -----------------------------------------------------------------------------
// seq_pattern_match
// Bit-serial overlapping pattern detector. Keeps the last PAT_W-1 bits seen,
// compares them plus the incoming bit against PATTERN, and suppresses matches
// until enough real bits have arrived to fill the window.
// Ports:
//   clk    in  rising-edge clock
//   reset  in  asynchronous, active-high reset
//   clr    in  synchronous clear of history and fill guard (new scan)
//   bit_en in  bit_in is valid and consumed this cycle
//   bit_in in  serial data bit, first bit in time first
//   match  out combinational: the window completed by bit_in equals PATTERN
// -----------------------------------------------------------------------------
module seq_pattern_match
  import seq_scan_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic bit_en,
  input  logic bit_in,
  output logic match
);

  localparam int                FILL_W   = cnt_width(PAT_W - 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  logic [PAT_W-2:0]  r_history;
  logic [FILL_W-1:0] r_fill;
  logic [PAT_W-1:0]  w_window;

  // Oldest history bit lands in the MSB, matching PATTERN[PAT_W-1] = first bit.
  assign w_window = {r_history, bit_in};

  // The fill guard stops the zeroed history from completing a false match.
  assign match = bit_en && (w_window == PATTERN) && (r_fill == FILL_MAX);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would make ordering of statements matter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_history <= '0;
      r_fill    <= '0;
    end else if (clr) begin
      r_history <= '0;
      r_fill    <= '0;
    end else if (bit_en) begin
      r_history <= w_window[PAT_W-2:0];
      if (r_fill != FILL_MAX) begin
        r_fill <= r_fill + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seq_scan_ctrl
// Accepts NUM_WORDS parallel words over a valid/ready handshake, serializes
// each MSB-first into seq_pattern_match, and counts matches across the burst.
// Detector history persists across word boundaries, so patterns spanning two
// words are found.
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous, active-high reset
//   start       in   begin a scan (only looked at in IDLE)
//   word_in     in   parallel data word
//   word_valid  in   producer has a word on word_in
//   word_ready  out  controller accepts word_in this cycle (LOAD)
//   match_pulse out  one-cycle pulse after the edge a match completes
//   match_count out  matches in the current/last scan, saturating
//   overflow    out  sticky: a match arrived with match_count already at max
//   busy        out  scan in progress (LOAD or SHIFT)
//   done        out  one-cycle pulse at scan end
// -----------------------------------------------------------------------------
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int               WORD_W    = DEF_WORD_W,
  parameter int               NUM_WORDS = 4,
  parameter int               PAT_W     = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN   = DEF_PATTERN,
  parameter int               CNT_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              match_pulse,
  output logic [CNT_W-1:0]  match_count,
  output logic              overflow,
  output logic              busy,
  output logic              done
);

  localparam int                BC_W      = cnt_width(WORD_W - 1);
  localparam int                WC_W      = cnt_width(NUM_WORDS);
  localparam logic [BC_W-1:0]   BIT_LAST  = BC_W'(WORD_W - 1);
  localparam logic [WC_W-1:0]   WORD_LAST = WC_W'(NUM_WORDS);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  scan_state_t       r_state;
  scan_state_t       w_next_state;
  logic [WORD_W-1:0] r_shreg;
  logic [BC_W-1:0]   r_bit_cnt;
  logic [WC_W-1:0]   r_word_cnt;
  logic              r_match_pulse;
  logic [CNT_W-1:0]  r_match_count;
  logic              r_overflow;

  logic w_start_scan;
  logic w_accept;
  logic w_shift;
  logic w_last_bit;
  logic w_last_word;
  logic w_match;

  assign w_start_scan = (r_state == IDLE) && start;
  assign w_accept     = (r_state == LOAD) && word_valid;
  assign w_shift      = (r_state == SHIFT);
  assign w_last_bit   = (r_bit_cnt == BIT_LAST);
  assign w_last_word  = (r_word_cnt == WORD_LAST);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment first keeps every path assigned, so no latch
  // is inferred for w_next_state.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start)      w_next_state = LOAD;
      LOAD:    if (word_valid) w_next_state = SHIFT;
      SHIFT:   if (w_last_bit) w_next_state = w_last_word ? DONE : LOAD;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (Moore, decoded from state)
  // ---------------------------------------------------------------------------
  always_comb begin
    word_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (r_state)
      LOAD: begin
        word_ready = 1'b1;
        busy       = 1'b1;
      end
      SHIFT:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Serializer and burst counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shreg    <= '0;
      r_bit_cnt  <= '0;
      r_word_cnt <= '0;
    end else begin
      if (w_start_scan) begin
        r_word_cnt <= '0;
      end
      if (w_accept) begin
        r_shreg    <= word_in;
        r_bit_cnt  <= '0;
        r_word_cnt <= r_word_cnt + 1'b1;
      end else if (w_shift) begin
        r_shreg   <= {r_shreg[WORD_W-2:0], 1'b0};
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
    end
  end

  seq_pattern_match #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN)
  ) u_match (
    .clk    (clk),
    .reset  (reset),
    .clr    (w_start_scan),
    .bit_en (w_shift),
    .bit_in (r_shreg[WORD_W-1]),
    .match  (w_match)
  );

  // ---------------------------------------------------------------------------
  // Match statistics; count and overflow hold until the next start.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_match_pulse <= 1'b0;
      r_match_count <= '0;
      r_overflow    <= 1'b0;
    end else begin
      r_match_pulse <= w_match;
      if (w_start_scan) begin
        r_match_count <= '0;
        r_overflow    <= 1'b0;
      end else if (w_match) begin
        if (r_match_count == CNT_MAX) begin
          r_overflow <= 1'b1;
        end else begin
          r_match_count <= r_match_count + 1'b1;
        end
      end
    end
  end

  assign match_pulse = r_match_pulse;
  assign match_count = r_match_count;
  assign overflow    = r_overflow;

endmodule
